// File: rtl/msg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// msg_arbiter_pkg : shared widths and state encoding for msg_arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package msg_arbiter_pkg;

  // Default channel widths (address, data, redundancy field)
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  // Arbiter handshake states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ACK_IN = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/msg_arbiter_calc_redun.sv
// ---------------------------------------------------------------------------
// msg_arbiter_calc_redun : redundancy of one message, XOR-fold of
//                          {src, dst, dat} into RSZ-bit chunks
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module msg_arbiter_calc_redun
  import msg_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);

  localparam int MW  = 2*ASZ + DSZ;
  localparam int NCH = (MW + RSZ - 1) / RSZ;
  localparam int PW  = NCH * RSZ;

  logic [PW-1:0] msg_pad;

  // Zero-extend the message so it splits into whole chunks
  assign msg_pad = PW'({src, dst, dat});

  // Fold all chunks together
  always_comb begin
    red = '0;
    for (int c = 0; c < NCH; c++) begin
      red = red ^ msg_pad[c*RSZ +: RSZ];
    end
  end

endmodule

`default_nettype wire

// File: rtl/msg_arbiter.sv
// ---------------------------------------------------------------------------
// msg_arbiter : 2:1 round-robin arbiter onto one four-phase message channel.
//               Optional redundancy check enabled by NS_ARB_REDUN_CHK_EN;
//               bad messages are acknowledged, never forwarded, and counted.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module msg_arbiter
  import msg_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic [7:0]     drop_cnt
);

  arb_state_e     state_q, state_d;
  logic           sel_q, sel_d;
  logic           last_q, last_d;
  logic           ready_q, ready_d;
  logic           snd_req_q, snd_req_d;
  logic [1:0]     ack_q, ack_d;
  logic [ASZ-1:0] src_q, src_d;
  logic [ASZ-1:0] dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;

  logic [1:0]     elig;
  logic           gnt_sel;
  logic           grant;
  logic           sel_req;
  logic [1:0]     bad;

  assign elig    = {rcv1_req & ~ack_q[1], rcv0_req & ~ack_q[0]};
  // Tie goes to the channel not served last; otherwise the lone eligible one
  assign gnt_sel = (elig == 2'b11) ? ~last_q : elig[1];
  assign grant   = (state_q == ST_IDLE) && ready_q && (|elig);
  assign sel_req = sel_q ? rcv1_req : rcv0_req;

`ifdef NS_ARB_REDUN_CHK_EN
  logic [RSZ-1:0] calc0, calc1;
  logic [7:0]     drop_q, drop_d;

  msg_arbiter_calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun0 (
    .src(rcv0_src), .dst(rcv0_dst), .dat(rcv0_dat), .red(calc0)
  );
  msg_arbiter_calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun1 (
    .src(rcv1_src), .dst(rcv1_dst), .dat(rcv1_dat), .red(calc1)
  );

  assign bad      = {calc1 != rcv1_red, calc0 != rcv0_red};
  assign drop_cnt = drop_q;

  // Saturating count of messages discarded at grant
  always_comb begin
    drop_d = drop_q;
    if (grant && bad[gnt_sel] && !(&drop_q)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) drop_q <= 8'h00;
    else        drop_q <= drop_d;
  end
`else
  assign bad      = 2'b00;
  assign drop_cnt = 8'h00;
`endif

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    ready_d   = 1'b1;
    snd_req_d = snd_req_q;
    ack_d     = ack_q;
    src_d     = src_q;
    dst_d     = dst_q;
    dat_d     = dat_q;
    red_d     = red_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          sel_d = gnt_sel;
          src_d = gnt_sel ? rcv1_src : rcv0_src;
          dst_d = gnt_sel ? rcv1_dst : rcv0_dst;
          dat_d = gnt_sel ? rcv1_dat : rcv0_dat;
          red_d = gnt_sel ? rcv1_red : rcv0_red;
          if (bad[gnt_sel]) begin
            ack_d[gnt_sel] = 1'b1;
            state_d        = ST_ACK_IN;
          end else begin
            snd_req_d = 1'b1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (snd0_ack) begin
          snd_req_d = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!snd0_ack) begin
          ack_d[sel_q] = 1'b1;
          state_d      = ST_ACK_IN;
        end
      end
      ST_ACK_IN: begin
        if (!sel_req) begin
          ack_d[sel_q] = 1'b0;
          last_d       = sel_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-message registers
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      ready_q   <= 1'b0;
      snd_req_q <= 1'b0;
      ack_q     <= 2'b00;
      src_q     <= '0;
      dst_q     <= '0;
      dat_q     <= '0;
      red_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      snd_req_q <= snd_req_d;
      ack_q     <= ack_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      dat_q     <= dat_d;
      red_q     <= red_d;
    end
  end

  assign ready    = ready_q;
  assign snd0_req = snd_req_q;
  assign rcv0_ack = ack_q[0];
  assign rcv1_ack = ack_q[1];
  assign snd0_src = src_q;
  assign snd0_dst = dst_q;
  assign snd0_dat = dat_q;
  assign snd0_red = red_q;

endmodule

`default_nettype wire
